iadc_integrator_chain: RTL
==========================

Name: iadc_integrator_chain

Overview:
- Parametrised cascade of ORDER unsigned integrators for the incremental ADC digital back-end.
- Runs integrate-and-dump over a conversion of OSR accepted samples.
- Presents the last-stage value as a conversion result with a one-cycle valid strobe, then clears all stages for the next conversion.
- Replaces the fixed 2nd-order, 9-bit-in / 18-bit-out integrator.

Parameters:
- WIDTH_IN, 9, unsigned input sample width.
- WIDTH_ACC, 24, width of every accumulator stage and of data_out; must be >= WIDTH_IN.
- ORDER, 2, number of cascaded integrator stages; legal range 1..4.
- OSR, 256, samples accepted per conversion; legal range 2..65535.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle request to begin a conversion.
- in_valid  in  1  data_in qualifier.
- data_in  in  WIDTH_IN  unsigned modulator/sample input.
- busy  out  1  high while a conversion is in progress (state RUN).
- out_valid  out  1  one-cycle strobe: data_out holds a new result.
- data_out  out  WIDTH_ACC  conversion result: last-stage accumulator.

Behaviour:
- Single clock domain (clk); reset is synchronous and active-low (rst_n).
- Reset, sampled at a rising edge with rst_n=0:
  - state=IDLE, all accumulators=0, sample counter=0.
  - busy=0, out_valid=0, data_out=0.
- Reset mid-conversion aborts the conversion: no out_valid, data_out=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1: clear all accumulators and the counter; next state RUN.
  - data_in and in_valid are ignored in IDLE.
- RUN (busy=1):
  - Each cycle with in_valid=1 accepts one sample and increments the counter.
  - in_valid=0: accumulators and counter hold.
  - start is ignored in RUN.
  - When the OSR-th sample is accepted, next state is DONE.
- DONE (one cycle):
  - data_out is loaded with the final last-stage value and out_valid=1, both at the edge entering DONE.
  - busy=0; next state IDLE.
  - start in DONE is ignored; the earliest accepted start is the cycle after out_valid.
- Integration is direct form (no inter-stage pipeline), evaluated on an accepted sample:
  - s0 = data_in, zero-extended to WIDTH_ACC.
  - acc_i_next = acc_i + acc_(i-1)_next for i = 1..ORDER, with acc_0_next = s0.
  - The last sample of a conversion fully propagates to acc_ORDER in the same edge.
- Arithmetic is unsigned modulo 2^WIDTH_ACC (wrap), unless the optional feature is enabled.
- data_out holds its value between conversions; it is not cleared by a new start.
- Latency: out_valid asserts exactly one cycle after the edge accepting the OSR-th sample.
- Conversion start-to-result with in_valid held high: OSR+1 cycles after the start edge.

Optional Feature:
- Macro: IADC_INTEG_SATURATE_EN.
- Defined:
  - Each stage computes its sum at WIDTH_ACC+1 bits.
  - If the sum is >= 2^WIDTH_ACC, the stage holds all-ones, and that clamped value feeds the next stage.
  - Once a stage clamps it stays at all-ones until cleared by start or rst_n.
- Undefined: plain modulo wrap per stage, no extra logic.

Test Plan:
- ORDER=1, OSR=4, in_valid=1, data_in 1,1,2,3 after start -> out_valid one cycle, data_out=7; busy high for 4 cycles.
- ORDER=2, OSR=4, data_in constant 1 -> acc1 1,2,3,4; acc2 1,3,6,10; data_out=10. A back-to-back second conversion with data_in=2 -> data_out=20 (proves clear on start).
- ORDER=2, OSR=4, data_in=1 with in_valid pattern 1,0,0,1,1,0,1 -> data_out=10; out_valid one cycle after the 4th valid; start pulses during RUN have no effect.
- WIDTH_IN=9, WIDTH_ACC=10, ORDER=2, OSR=4, data_in=511:
  - Without macro -> data_out=1014.
  - With IADC_INTEG_SATURATE_EN -> data_out=1023.
- rst_n=0 for one cycle after 2 of 4 samples -> busy=0, out_valid never asserts, data_out=0. A subsequent full conversion of constant 1 (ORDER=2) -> 10.
- Power-up: data_in toggling with no start -> busy=0, out_valid=0, data_out=0 for 20 cycles.

Source files
------------

// File: rtl/iadc_integrator_chain.sv
// -----------------------------------------------------------------------------
// iadc_integrator_chain
//
// Cascade of ORDER unsigned integrators for the incremental ADC back-end.
// A conversion is started by a one-cycle start pulse. Exactly OSR qualified
// samples are then integrated. The last-stage accumulator is presented on
// data_out with a one-cycle out_valid strobe. Every stage is cleared when
// the next conversion starts.
//
// Parameters:
//   WIDTH_IN   unsigned input sample width
//   WIDTH_ACC  width of every accumulator stage and of data_out (>= WIDTH_IN)
//   ORDER      number of cascaded integrator stages (1..4)
//   OSR        samples accepted per conversion (2..65535)
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   start      one-cycle request to begin a conversion (honoured in IDLE only)
//   in_valid   data_in qualifier
//   data_in    unsigned modulator/sample input
//   busy       high while a conversion is in progress (state RUN)
//   out_valid  one-cycle strobe: data_out holds a new result
//   data_out   conversion result (last-stage accumulator); holds between results
//
// Optional feature:
//   IADC_INTEG_SATURATE_EN  when defined, each stage clamps at all-ones instead
//                           of wrapping modulo 2^WIDTH_ACC.
// -----------------------------------------------------------------------------
module iadc_integrator_chain #(
  parameter int WIDTH_IN  = 9,
  parameter int WIDTH_ACC = 24,
  parameter int ORDER     = 2,
  parameter int OSR       = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 in_valid,
  input  logic [WIDTH_IN-1:0]  data_in,
  output logic                 busy,
  output logic                 out_valid,
  output logic [WIDTH_ACC-1:0] data_out
);

  localparam int CNT_W = $clog2(OSR);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q;
  logic [WIDTH_ACC-1:0] acc_q [ORDER];
  logic [WIDTH_ACC-1:0] acc_d [ORDER];
  logic                 accept;
  logic                 last_sample;

  assign accept      = (state_q == RUN) && in_valid;
  assign last_sample = accept && (cnt_q == CNT_W'(OSR - 1));
  assign busy        = (state_q == RUN);

  // Direct-form integration: each stage adds the freshly computed value of the
  // stage before it, so a sample ripples through the whole chain in one edge.
  always_comb begin : integrate
    logic [WIDTH_ACC-1:0] feed;
`ifdef IADC_INTEG_SATURATE_EN
    logic [WIDTH_ACC:0]   sum;
`endif
    // NOTE: 'feed' is a combinational temporary chained through the loop, so
    // it must use blocking '='; every output gets a value before any branch,
    // which keeps this block free of inferred latches.
    feed = WIDTH_ACC'(data_in);
    for (int i = 0; i < ORDER; i++) begin
`ifdef IADC_INTEG_SATURATE_EN
      // A stage at all-ones stays there: any non-zero feed overflows again,
      // and a zero feed leaves it unchanged.
      sum      = {1'b0, acc_q[i]} + {1'b0, feed};
      acc_d[i] = sum[WIDTH_ACC] ? {WIDTH_ACC{1'b1}} : sum[WIDTH_ACC-1:0];
`else
      acc_d[i] = acc_q[i] + feed;
`endif
      feed = acc_d[i];
    end
  end

  always_comb begin : next_state
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_sample) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      out_valid <= 1'b0;
      data_out  <= '0;
      // NOTE: the accumulator array is a handful of flops, not a RAM, and a
      // reset mid-conversion must leave it cleared, so it is reset explicitly.
      for (int i = 0; i < ORDER; i++) acc_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      out_valid <= last_sample;
      if (last_sample) data_out <= acc_d[ORDER-1];

      if ((state_q == IDLE) && start) begin
        cnt_q <= '0;
        for (int i = 0; i < ORDER; i++) acc_q[i] <= '0;
      end else if (accept) begin
        cnt_q <= last_sample ? '0 : cnt_q + 1'b1;
        for (int i = 0; i < ORDER; i++) acc_q[i] <= acc_d[i];
      end
    end
  end

endmodule
